controle_disparo: RTL and testbench

CONTROLE_DISPARO -- requirements
Module: controle_disparo

---
 rtl/torreta_pkg.sv | 25 ++
 rtl/contador_m.sv | 35 +++
 rtl/controle_disparo.sv | 104 ++++++++++
 tb/tb_controle_disparo.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/torreta_pkg.sv
`default_nettype none
// =============================================================================
// Module      : torreta_pkg
// Description : State encodings and ammunition width shared by the turret logic
// Revision    : 1.0 - initial release
// =============================================================================
package torreta_pkg;

   localparam int c_MUNICAO_W = 4;

   localparam logic [2:0] c_PRONTO          = 3'b000;
   localparam logic [2:0] c_DISPARANDO      = 3'b001;
   localparam logic [2:0] c_DECREMENTA      = 3'b010;
   localparam logic [2:0] c_PEDE_RECARGA    = 3'b011;
   localparam logic [2:0] c_AGUARDA_RECARGA = 3'b100;
   localparam logic [2:0] c_RECARREGADO     = 3'b101;
   localparam logic [2:0] c_INVALIDO        = 3'b111;

   // Unused codes are reported as all-ones so they stand out on the debug bus
   function automatic logic [2:0] f_db_estado(input logic [2:0] estado);
      return (estado <= c_RECARREGADO) ? estado : c_INVALIDO;
   endfunction

endpackage
`default_nettype wire

// File: rtl/contador_m.sv
`default_nettype none
// =============================================================================
// Module      : contador_m
// Description : Mod-M counter with synchronous clear, enable and terminal count
// Revision    : 1.0 - initial release
// =============================================================================
module contador_m #(
   parameter int M = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_tc
);

   localparam int c_W = (M > 1) ? $clog2(M) : 1;
   localparam logic [c_W-1:0] c_ULTIMO = c_W'(M - 1);

   logic [c_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= (r_count == c_ULTIMO) ? '0 : r_count + c_W'(1);
      end
   end

   assign o_tc = i_enable && (r_count == c_ULTIMO);

endmodule
`default_nettype wire

// File: rtl/controle_disparo.sv
`default_nettype none
// =============================================================================
// Module      : controle_disparo
// Description : Turret fire/reload sequencer with Moore-decoded outputs.
//               Define AUTO_RECARGA_EN to request a reload automatically when
//               the magazine empties.
// Revision    : 1.0 - initial release
// =============================================================================
module controle_disparo
   import torreta_pkg::*;
#(
   parameter int MUNICAO_MAX = 6,
   parameter int T_GATILHO   = 25000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   disparar,
   input  logic                   recarregar,
   input  logic                   fim_recarga,
   output logic                   gatilho,
   output logic                   iniciar_recarga,
   output logic [c_MUNICAO_W-1:0] municao,
   output logic                   pronto,
   output logic [2:0]             db_estado
);

   localparam logic [c_MUNICAO_W-1:0] c_CHEIO = c_MUNICAO_W'(MUNICAO_MAX);

   logic [2:0]             r_estado;
   logic [2:0]             w_prox;
   logic [c_MUNICAO_W-1:0] r_municao;
   logic                   w_disparando;
   logic                   w_fim_pulso;

   assign w_disparando = (r_estado == c_DISPARANDO);

   // Cleared outside DISPARANDO so every shot starts from zero
   contador_m #(
      .M (T_GATILHO)
   ) u_contador (
      .clk      (clock),
      .rst_n    (reset),
      .i_clear  (!w_disparando),
      .i_enable (w_disparando),
      .o_tc     (w_fim_pulso)
   );

   always_comb begin
      w_prox = r_estado;
      case (r_estado)
         c_PRONTO: begin
            if (disparar) begin
               if (r_municao != '0)
                  w_prox = c_DISPARANDO;
`ifdef AUTO_RECARGA_EN
               else
                  w_prox = c_PEDE_RECARGA;
`endif
            end else if (recarregar && (r_municao < c_CHEIO)) begin
               w_prox = c_PEDE_RECARGA;
            end
         end
         c_DISPARANDO: begin
            if (w_fim_pulso)
               w_prox = c_DECREMENTA;
         end
         c_DECREMENTA: begin
`ifdef AUTO_RECARGA_EN
            w_prox = (r_municao == c_MUNICAO_W'(1)) ? c_PEDE_RECARGA : c_PRONTO;
`else
            w_prox = c_PRONTO;
`endif
         end
         c_PEDE_RECARGA:    w_prox = c_AGUARDA_RECARGA;
         c_AGUARDA_RECARGA: begin
            if (fim_recarga)
               w_prox = c_RECARREGADO;
         end
         c_RECARREGADO:     w_prox = c_PRONTO;
         default:           w_prox = c_PRONTO;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_estado  <= c_PRONTO;
         r_municao <= c_CHEIO;
      end else begin
         r_estado <= w_prox;
         if (r_estado == c_DECREMENTA)
            r_municao <= r_municao - c_MUNICAO_W'(1);
         else if (r_estado == c_RECARREGADO)
            r_municao <= c_CHEIO;
      end
   end

   assign gatilho         = w_disparando;
   assign iniciar_recarga = (r_estado == c_PEDE_RECARGA);
   assign pronto          = (r_estado == c_PRONTO);
   assign municao         = r_municao;
   assign db_estado       = f_db_estado(r_estado);

endmodule
`default_nettype wire

// File: tb/tb_controle_disparo.sv
`default_nettype none
// =============================================================================
// Module      : tb_controle_disparo
// Description : Directed scoreboard bench for controle_disparo (T_GATILHO=4,
//               MUNICAO_MAX=3); AUTO_RECARGA_EN selects the matching scenario.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_controle_disparo;

   logic       clock = 1'b0;
   logic       reset;
   logic       disparar;
   logic       recarregar;
   logic       fim_recarga;
   logic       gatilho;
   logic       iniciar_recarga;
   logic [3:0] municao;
   logic       pronto;
   logic [2:0] db_estado;

   int         errors = 0;
   int         checks = 0;
   logic [9:0] q_esp[$];

   controle_disparo #(
      .MUNICAO_MAX (3),
      .T_GATILHO   (4)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .disparar        (disparar),
      .recarregar      (recarregar),
      .fim_recarga     (fim_recarga),
      .gatilho         (gatilho),
      .iniciar_recarga (iniciar_recarga),
      .municao         (municao),
      .pronto          (pronto),
      .db_estado       (db_estado)
   );

   always #5 clock = ~clock;

   // Expected output word: {gatilho, iniciar_recarga, municao, pronto, db_estado}
   task automatic esp(input logic g, input logic ir, input logic [3:0] mun,
                      input logic pr, input logic [2:0] db);
      q_esp.push_back({g, ir, mun, pr, db});
   endtask

   task automatic verif(input string tag);
      logic [9:0] obs;
      logic [9:0] e;
      obs = {gatilho, iniciar_recarga, municao, pronto, db_estado};
      checks++;
      if (q_esp.size() == 0) begin
         errors++;
         $error("FAIL %s: observed=%b expected=<scoreboard empty>", tag, obs);
      end else begin
         e = q_esp.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, e);
         end
      end
   endtask

   // Called at a negedge: drive, let one rising edge pass, check at next negedge
   task automatic passo(input logic d, input logic r, input logic f, input string tag);
      disparar    = d;
      recarregar  = r;
      fim_recarga = f;
      @(posedge clock);
      @(negedge clock);
      verif(tag);
   endtask

   // Full shot starting in PRONTO with mun_ini rounds left
   task automatic tiro(input logic [3:0] mun_ini, input logic rec, input string tag);
      esp(1'b1, 1'b0, mun_ini, 1'b0, 3'b001);
      passo(1'b1, rec, 1'b0, {tag, "_disp0"});
      for (int i = 1; i < 4; i++) begin
         esp(1'b1, 1'b0, mun_ini, 1'b0, 3'b001);
         passo(1'b0, 1'b0, 1'b0, {tag, "_disp"});
      end
      esp(1'b0, 1'b0, mun_ini, 1'b0, 3'b010);
      passo(1'b0, 1'b0, 1'b0, {tag, "_decr"});
   endtask

   initial begin
      reset       = 1'b0;
      disparar    = 1'b0;
      recarregar  = 1'b0;
      fim_recarga = 1'b0;
      repeat (2) @(negedge clock);
      esp(1'b0, 1'b0, 4'd3, 1'b1, 3'b000);
      verif("reset_state");
      reset = 1'b1;

      // Single shot: 4 trigger cycles, then decrement
      tiro(4'd3, 1'b0, "shot1");
      esp(1'b0, 1'b0, 4'd2, 1'b1, 3'b000);
      passo(1'b0, 1'b0, 1'b0, "shot1_ready");

      // Fire and reload together: fire wins
      tiro(4'd2, 1'b1, "shot2_prio");
      esp(1'b0, 1'b0, 4'd1, 1'b1, 3'b000);
      passo(1'b0, 1'b0, 1'b0, "shot2_ready");

      tiro(4'd1, 1'b0, "shot3");
`ifdef AUTO_RECARGA_EN
      esp(1'b0, 1'b1, 4'd0, 1'b0, 3'b011);
      passo(1'b0, 1'b0, 1'b0, "auto_pede");
      esp(1'b0, 1'b0, 4'd0, 1'b0, 3'b100);
      passo(1'b0, 1'b0, 1'b0, "auto_aguarda");
      esp(1'b0, 1'b0, 4'd0, 1'b0, 3'b100);
      passo(1'b0, 1'b0, 1'b0, "auto_aguarda2");
      esp(1'b0, 1'b0, 4'd0, 1'b0, 3'b101);
      passo(1'b0, 1'b0, 1'b1, "auto_recarregado");
      esp(1'b0, 1'b0, 4'd3, 1'b1, 3'b000);
      passo(1'b0, 1'b0, 1'b0, "auto_cheio");
`else
      esp(1'b0, 1'b0, 4'd0, 1'b1, 3'b000);
      passo(1'b0, 1'b0, 1'b0, "empty_ready");
      esp(1'b0, 1'b0, 4'd0, 1'b1, 3'b000);
      passo(1'b1, 1'b0, 1'b0, "empty_fire_ignored");
      esp(1'b0, 1'b0, 4'd0, 1'b1, 3'b000);
      passo(1'b1, 1'b0, 1'b0, "empty_fire_held");
      esp(1'b0, 1'b1, 4'd0, 1'b0, 3'b011);
      passo(1'b0, 1'b1, 1'b0, "manual_pede");
      esp(1'b0, 1'b0, 4'd0, 1'b0, 3'b100);
      passo(1'b0, 1'b1, 1'b0, "manual_aguarda");
      esp(1'b0, 1'b0, 4'd0, 1'b0, 3'b100);
      passo(1'b1, 1'b0, 1'b0, "aguarda_ignora_disp");
      esp(1'b0, 1'b0, 4'd0, 1'b0, 3'b101);
      passo(1'b0, 1'b0, 1'b1, "manual_recarregado");
      esp(1'b0, 1'b0, 4'd3, 1'b1, 3'b000);
      passo(1'b0, 1'b0, 1'b0, "manual_cheio");
`endif

      // Full magazine ignores reload; stray completion pulse is harmless
      esp(1'b0, 1'b0, 4'd3, 1'b1, 3'b000);
      passo(1'b0, 1'b1, 1'b0, "reload_full_ignored");
      esp(1'b0, 1'b0, 4'd3, 1'b1, 3'b000);
      passo(1'b0, 1'b0, 1'b0, "reload_full_after");
      esp(1'b0, 1'b0, 4'd3, 1'b1, 3'b000);
      passo(1'b0, 1'b0, 1'b1, "stray_fim");

      // Reset asserted in the second trigger cycle
      esp(1'b1, 1'b0, 4'd3, 1'b0, 3'b001);
      passo(1'b1, 1'b0, 1'b0, "abort_disp0");
      esp(1'b1, 1'b0, 4'd3, 1'b0, 3'b001);
      passo(1'b0, 1'b0, 1'b0, "abort_disp1");
      #2 reset = 1'b0;
      #1;
      esp(1'b0, 1'b0, 4'd3, 1'b1, 3'b000);
      verif("reset_async");
      @(posedge clock);
      @(negedge clock);
      esp(1'b0, 1'b0, 4'd3, 1'b1, 3'b000);
      verif("reset_hold");
      reset = 1'b1;
      esp(1'b0, 1'b0, 4'd3, 1'b1, 3'b000);
      passo(1'b0, 1'b0, 1'b0, "post_reset");

      // Timer must restart from zero after the aborted shot
      tiro(4'd3, 1'b0, "shot_after_reset");
      esp(1'b0, 1'b0, 4'd2, 1'b1, 3'b000);
      passo(1'b0, 1'b0, 1'b0, "shot_after_reset_ready");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
